// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Types and constants shared by the half-precision operation scheduler and its
// round-robin arbiter.
//   FP_W          : operand/result width of the add and mul units
//   SETTLE_W      : width of the settle counter (SETTLE_CYCLES is 1..15)
//   op_t          : op select, same encoding as the chip select pin
//   sched_state_t : scheduler FSM states
// ----------------------------------------------------------------------------
package fpu_pkg;

  localparam int FP_W     = 16;
  localparam int SETTLE_W = 4;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_ADD = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/fpu_rr_arb2.sv
// ----------------------------------------------------------------------------
// fpu_rr_arb2
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req        in  2  request vector
//   last_grant in  1  index of the requester granted most recently
//   gnt        out 2  one-hot grant, zero when nothing is requested
//   gnt_idx    out 1  index of the granted requester (0 when gnt is zero)
// ----------------------------------------------------------------------------
module fpu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic pref;

  // The requester that did not go last gets first pick; a lone requester is
  // always served, so continuous single-source traffic never stalls.
  always_comb begin
    pref    = ~last_grant;
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    if (req[pref]) begin
      gnt[pref] = 1'b1;
      gnt_idx   = pref;
    end else if (req[last_grant]) begin
      gnt[last_grant] = 1'b1;
      gnt_idx         = last_grant;
    end
  end

endmodule

// File: rtl/fpu_op_scheduler.sv
// ----------------------------------------------------------------------------
// fpu_op_scheduler
// Shares one combinational half-precision adder and multiplier between two
// requesters. An accepted operation has its operands registered onto the unit
// inputs, held for SETTLE_CYCLES cycles, and the selected unit's result and
// valid flag are captured and returned to the owning requester.
//
// Handshakes: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready is one-hot and only ever asserted in
// IDLE. A response is consumed on a rising edge where rsp_valid[owner] and
// rsp_ready[owner] are both high; rsp_data/rsp_flag are stable while
// rsp_valid is high, and the non-owner's rsp_ready is ignored.
//
// Ports:
//   clock, reset             clock and asynchronous active-high reset
//   req_valid/ready/op/a/b   per-requester operation request (op 1=add 0=mul)
//   rsp_valid/ready          per-requester response handshake
//   rsp_data, rsp_flag       captured result and unit valid flag (shared)
//   unit_a, unit_b           registered operands driven to both units
//   add_out/valid, mul_*     unit results
//   busy                     high whenever the FSM is not in IDLE
//   op_count                 completed-operation counter (wraps)
//   dbg_state                current FSM state
// ----------------------------------------------------------------------------
module fpu_op_scheduler
  import fpu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int N_REQ         = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_op,
  input  logic [N_REQ-1:0][FP_W-1:0]  req_a,
  input  logic [N_REQ-1:0][FP_W-1:0]  req_b,
  output logic [N_REQ-1:0]            rsp_valid,
  input  logic [N_REQ-1:0]            rsp_ready,
  output logic [FP_W-1:0]             rsp_data,
  output logic                        rsp_flag,
  output logic [FP_W-1:0]             unit_a,
  output logic [FP_W-1:0]             unit_b,
  input  logic [FP_W-1:0]             add_out,
  input  logic                        add_valid,
  input  logic [FP_W-1:0]             mul_out,
  input  logic                        mul_valid,
  output logic                        busy,
  output logic [15:0]                 op_count,
  output sched_state_t                dbg_state
);

  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

  sched_state_t          state_q, state_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  op_t                   op_r_q, op_r_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [FP_W-1:0]       unit_a_q, unit_a_d;
  logic [FP_W-1:0]       unit_b_q, unit_b_d;
  logic [FP_W-1:0]       rsp_data_q, rsp_data_d;
  logic                  rsp_flag_q, rsp_flag_d;
  logic [15:0]           op_count_q, op_count_d;

  logic [1:0]            gnt;
  logic                  gnt_idx;

  fpu_rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    op_r_d       = op_r_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    unit_a_d     = unit_a_q;
    unit_b_d     = unit_b_q;
    rsp_data_d   = rsp_data_q;
    rsp_flag_d   = rsp_flag_q;
    op_count_d   = op_count_q;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        // gnt is already qualified by req_valid, so any grant is a transfer.
        req_ready = gnt;
        if (gnt != 2'b00) begin
          unit_a_d     = req_a[gnt_idx];
          unit_b_d     = req_b[gnt_idx];
          op_r_d       = op_t'(req_op[gnt_idx]);
          owner_d      = gnt_idx;
          last_grant_d = gnt_idx;
          settle_cnt_d = SETTLE_INIT;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (settle_cnt_q != '0) begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end else begin
          // Both units see the same operands; keep only the selected one.
          rsp_data_d = (op_r_q == OP_ADD) ? add_out   : mul_out;
          rsp_flag_d = (op_r_q == OP_ADD) ? add_valid : mul_valid;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      op_r_q       <= OP_MUL;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;  // requester 0 wins the first contention
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      rsp_data_q   <= '0;
      rsp_flag_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      op_r_q       <= op_r_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      unit_a_q     <= unit_a_d;
      unit_b_q     <= unit_b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_flag_q   <= rsp_flag_d;
      op_count_q   <= op_count_d;
    end
  end

  // The response belongs to the owner for the whole of RESP.
  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;
  assign unit_a    = unit_a_q;
  assign unit_b    = unit_b_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = op_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
module tb_fpu_op_scheduler;

  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]       req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [1:0][15:0] req_a, req_b;
  logic [15:0]      rsp_data, unit_a, unit_b, add_out, mul_out, op_count;
  logic             rsp_flag, add_valid, mul_valid, busy;
  logic [1:0]       dbg_state;
  logic             add_vld, mul_vld;

  fpu_op_scheduler #(.SETTLE_CYCLES(S), .N_REQ(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .unit_a(unit_a), .unit_b(unit_b),
    .add_out(add_out), .add_valid(add_valid),
    .mul_out(mul_out), .mul_valid(mul_valid),
    .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
  );

  // Stand-in arithmetic units: known half-precision pairs give true results,
  // anything else a distinct deterministic value per unit.
  function automatic logic [15:0] unit_add(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3C00 && b == 16'h4000) return 16'h4200;
    return a + b;
  endfunction

  function automatic logic [15:0] unit_mul(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h4000 && b == 16'h4200) return 16'h4600;
    return {a[7:0], b[7:0]} ^ 16'h5A5A;
  endfunction

  assign add_out   = unit_add(unit_a, unit_b);
  assign mul_out   = unit_mul(unit_a, unit_b);
  assign add_valid = add_vld;
  assign mul_valid = mul_vld;

  // ---------------- reference model / scoreboard ----------------
  logic [16:0] exp_q[$];   // {flag, data} per accepted operation
  logic [15:0] exp_count;
  int          last_g;
  int          n_vec = 0;
  int          n_err = 0;

  // Both pending: whoever did not go last. Otherwise the only one pending.
  function automatic int exp_grant(input logic [1:0] v, input int last);
    if (v == 2'b11) return (last == 0) ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  function automatic logic [15:0] model_result(input logic op, input logic [15:0] a,
                                               input logic [15:0] b);
    return op ? unit_add(a, b) : unit_mul(a, b);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic issue(input int r, input logic op, input logic [15:0] a, input logic [15:0] b);
    req_op[r]    = op;
    req_a[r]     = a;
    req_b[r]     = b;
    req_valid[r] = 1'b1;
  endtask

  // Returns after the transfer edge, at the following falling edge.
  task automatic wait_grant(output int g, output bit ok);
    g  = 0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if ((req_ready & req_valid) != 2'b00) begin
        g  = req_ready[1] ? 1 : 0;
        ok = 1'b1;
        exp_q.push_back({(req_op[g] ? add_vld : mul_vld),
                         model_result(req_op[g], req_a[g], req_b[g])});
      end
      tick();
    end
  endtask

  // lat = rising edges after the transfer edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (rsp_valid != 2'b00) ok = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
  endtask

  // After transfer the winner's inputs are scrambled to show the in-flight
  // operation does not depend on them.
  task automatic grant_and_respond(input bit keep_valid, output int g, output bit gok,
                                   output int lat, output bit rok, output logic [16:0] exp);
    wait_grant(g, gok);
    lat = 0;
    rok = 1'b0;
    exp = '0;
    if (gok) begin
      req_valid[g] = keep_valid;
      req_op[g]    = 1'($urandom_range(0, 1));
      req_a[g]     = 16'($urandom);
      req_b[g]     = 16'($urandom);
      wait_rsp(lat, rok);
      if (exp_q.size() > 0) exp = exp_q.pop_front();
    end
  endtask

  task automatic complete(input int r);
    rsp_ready[r] = 1'b1;
    tick();
    rsp_ready[r] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req_valid = 2'b00; rsp_ready = 2'b00; req_op = 2'b00;
    req_a = '0; req_b = '0; add_vld = 1'b0; mul_vld = 1'b0;
    reset = 1'b1;
    tick(); tick();
    #1;
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
    n_vec++; if ({rsp_data, rsp_flag} !== 17'h0) begin n_err++; $display("FAIL reset_rsp got %h/%b want 0/0", rsp_data, rsp_flag); end
    n_vec++; if ({unit_a, unit_b} !== 32'h0) begin n_err++; $display("FAIL reset_unit got %h %h want 0 0", unit_a, unit_b); end
    n_vec++; if ({busy, dbg_state} !== 3'b000) begin n_err++; $display("FAIL reset_busy got %b/%0d want 0/0", busy, dbg_state); end
    n_vec++; if (op_count !== 16'h0) begin n_err++; $display("FAIL reset_op_count got %h want 0", op_count); end
    @(negedge clock);
    reset     = 1'b0;
    exp_count = 16'h0;
    last_g    = 1;
    exp_q.delete();
  endtask

  task automatic test_contention();
    int g, lat, eg; bit gok, rok; logic [16:0] exp;
    issue(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    issue(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    for (int k = 0; k < 4; k++) begin
      add_vld = 1'($urandom_range(0, 1));
      mul_vld = 1'($urandom_range(0, 1));
      eg = exp_grant(2'b11, last_g);
      grant_and_respond(1'b1, g, gok, lat, rok, exp);
      last_g = eg;
      n_vec++; if (!gok || g != eg) begin n_err++; $display("FAIL cont_grant[%0d] got %0d (ok=%0d) want %0d", k, g, gok, eg); end
      n_vec++; if (!rok || lat != S) begin n_err++; $display("FAIL cont_latency[%0d] got %0d want %0d", k, lat, S); end
      n_vec++; if (rsp_valid !== (2'b01 << eg)) begin n_err++; $display("FAIL cont_rsp_valid[%0d] got %b want %b", k, rsp_valid, 2'b01 << eg); end
      n_vec++; if ({rsp_flag, rsp_data} !== exp) begin n_err++; $display("FAIL cont_data[%0d] got %b/%h want %b/%h", k, rsp_flag, rsp_data, exp[16], exp[15:0]); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL cont_busy_resp[%0d] got %b want 1", k, busy); end
      complete(g);
      exp_count = exp_count + 16'd1;
      #1;
      n_vec++; if (busy !== 1'b0 || op_count !== exp_count) begin n_err++; $display("FAIL cont_idle[%0d] got busy=%b cnt=%h want busy=0 cnt=%h", k, busy, op_count, exp_count); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_basic_add();
    int g, lat; bit gok, rok; logic [16:0] exp;
    add_vld = 1'b1; mul_vld = 1'b0;
    issue(0, 1'b1, 16'h3C00, 16'h4000);
    grant_and_respond(1'b0, g, gok, lat, rok, exp);
    last_g = 0;
    n_vec++; if (!gok || g != 0) begin n_err++; $display("FAIL add_grant got %0d (ok=%0d) want 0", g, gok); end
    n_vec++; if (!rok || lat != S) begin n_err++; $display("FAIL add_latency got %0d want %0d", lat, S); end
    n_vec++; if ({unit_a, unit_b} !== {16'h3C00, 16'h4000}) begin n_err++; $display("FAIL add_unit_hold got %h %h want 3c00 4000", unit_a, unit_b); end
    n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL add_rsp_valid got %b want 01", rsp_valid); end
    n_vec++; if (rsp_data !== 16'h4200 || rsp_data !== exp[15:0]) begin n_err++; $display("FAIL add_data got %h want 4200", rsp_data); end
    n_vec++; if (rsp_flag !== 1'b1) begin n_err++; $display("FAIL add_flag got %b want 1", rsp_flag); end
    complete(0);
    exp_count = exp_count + 16'd1;
    #1;
    n_vec++; if (op_count !== exp_count || rsp_valid !== 2'b00) begin n_err++; $display("FAIL add_done got cnt=%h rv=%b want cnt=%h rv=00", op_count, rsp_valid, exp_count); end
  endtask

  task automatic test_basic_mul();
    int g, lat; bit gok, rok; logic [16:0] exp;
    add_vld = 1'b0; mul_vld = 1'b1;
    issue(1, 1'b0, 16'h4000, 16'h4200);
    grant_and_respond(1'b0, g, gok, lat, rok, exp);
    last_g = 1;
    n_vec++; if (!gok || g != 1) begin n_err++; $display("FAIL mul_grant got %0d (ok=%0d) want 1", g, gok); end
    n_vec++; if (!rok || lat != S) begin n_err++; $display("FAIL mul_latency got %0d want %0d", lat, S); end
    n_vec++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL mul_rsp_valid got %b want 10", rsp_valid); end
    n_vec++; if (rsp_data !== 16'h4600 || {rsp_flag, rsp_data} !== exp) begin n_err++; $display("FAIL mul_data got %b/%h want 1/4600", rsp_flag, rsp_data); end
    complete(1);
    exp_count = exp_count + 16'd1;
    #1;
    n_vec++; if (op_count !== exp_count) begin n_err++; $display("FAIL mul_count got %h want %h", op_count, exp_count); end
  endtask

  task automatic test_backpressure();
    int g, lat; bit gok, rok; logic [16:0] exp;
    add_vld = 1'($urandom_range(0, 1)); mul_vld = 1'($urandom_range(0, 1));
    issue(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    grant_and_respond(1'b0, g, gok, lat, rok, exp);
    last_g = 0;
    n_vec++; if (!gok || g != 0 || !rok || lat != S) begin n_err++; $display("FAIL bp_issue got g=%0d lat=%0d want g=0 lat=%0d", g, lat, S); end
    issue(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      n_vec++;
      if ({rsp_valid, rsp_flag, rsp_data, req_ready} !== {2'b01, exp, 2'b00}) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got rv=%b d=%b/%h rdy=%b want rv=01 d=%b/%h rdy=00",
                 i, rsp_valid, rsp_flag, rsp_data, req_ready, exp[16], exp[15:0]);
      end
    end
    req_valid[1] = 1'b0;
    rsp_ready    = 2'b11;
    tick();
    rsp_ready = 2'b00;
    exp_count = exp_count + 16'd1;
    #1;
    n_vec++; if (rsp_valid !== 2'b00 || op_count !== exp_count || busy !== 1'b0 || req_ready !== 2'b00) begin
      n_err++; $display("FAIL bp_release got rv=%b cnt=%h busy=%b rdy=%b want 00/%h/0/00", rsp_valid, op_count, busy, req_ready, exp_count); end
  endtask

  task automatic test_random();
    int g, lat, eg, d; bit gok, rok; logic [16:0] exp; logic [1:0] mask;
    for (int k = 0; k < 16; k++) begin
      mask = 2'($urandom_range(1, 3));
      add_vld = 1'($urandom_range(0, 1)); mul_vld = 1'($urandom_range(0, 1));
      for (int r = 0; r < 2; r++)
        if (mask[r]) issue(r, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      eg = exp_grant(mask, last_g);
      grant_and_respond(1'b0, g, gok, lat, rok, exp);
      last_g    = eg;
      req_valid = 2'b00;
      n_vec++; if (!gok || g != eg) begin n_err++; $display("FAIL rnd_grant[%0d] got %0d want %0d", k, g, eg); end
      n_vec++; if (!rok || lat != S || rsp_valid !== (2'b01 << eg)) begin n_err++; $display("FAIL rnd_rsp[%0d] got lat=%0d rv=%b want lat=%0d rv=%b", k, lat, rsp_valid, S, 2'b01 << eg); end
      n_vec++; if ({rsp_flag, rsp_data} !== exp) begin n_err++; $display("FAIL rnd_data[%0d] got %b/%h want %b/%h", k, rsp_flag, rsp_data, exp[16], exp[15:0]); end
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) tick();
      complete(g);
      exp_count = exp_count + 16'd1;
      #1;
      n_vec++; if (op_count !== exp_count) begin n_err++; $display("FAIL rnd_count[%0d] got %h want %h", k, op_count, exp_count); end
    end
  endtask

  task automatic test_mid_reset();
    int g, lat; bit gok, rok, stray; logic [16:0] exp;
    issue(1, 1'b1, 16'($urandom), 16'($urandom));
    wait_grant(g, gok);
    req_valid = 2'b00;
    n_vec++; if (!gok || g != exp_grant(2'b10, last_g)) begin n_err++; $display("FAIL rst_issue_grant got %0d want 1", g); end
    tick();
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({rsp_valid, req_ready, busy, rsp_flag, rsp_data, unit_a, unit_b, op_count} !== '0) begin
      n_err++;
      $display("FAIL rst_async got rv=%b busy=%b d=%h ua=%h ub=%h cnt=%h want all 0",
               rsp_valid, busy, rsp_data, unit_a, unit_b, op_count);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    exp_count = 16'h0;
    last_g    = 1;
    stray     = 1'b0;
    for (int i = 0; i < S + 4; i++) begin
      #1;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) stray = 1'b1;
      tick();
    end
    n_vec++; if (stray) begin n_err++; $display("FAIL rst_no_rsp got a response or busy after reset want none"); end
    add_vld = 1'b1; mul_vld = 1'b1;
    issue(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    issue(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    grant_and_respond(1'b0, g, gok, lat, rok, exp);
    req_valid = 2'b00;
    last_g    = 0;
    n_vec++; if (!gok || g != 0) begin n_err++; $display("FAIL rst_first_grant got %0d want 0", g); end
    n_vec++; if (!rok || {rsp_flag, rsp_data} !== exp) begin n_err++; $display("FAIL rst_data got %b/%h want %b/%h", rsp_flag, rsp_data, exp[16], exp[15:0]); end
    complete(g);
    exp_count = exp_count + 16'd1;
    #1;
    n_vec++; if (op_count !== exp_count) begin n_err++; $display("FAIL rst_count got %h want %h", op_count, exp_count); end
  endtask

  task automatic test_wrap();
    int g, lat, eg; bit gok, rok; logic [16:0] exp;
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    #1;
    exp_count = 16'hFFFF;
    n_vec++; if (op_count !== exp_count) begin n_err++; $display("FAIL wrap_preload got %h want ffff", op_count); end
    add_vld = 1'b0; mul_vld = 1'b0;
    issue(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    eg = exp_grant(2'b10, last_g);
    grant_and_respond(1'b0, g, gok, lat, rok, exp);
    last_g = eg;
    n_vec++; if (!gok || g != eg || !rok) begin n_err++; $display("FAIL wrap_issue got g=%0d ok=%0d/%0d want g=%0d", g, gok, rok, eg); end
    n_vec++; if (rsp_flag !== 1'b0 || {rsp_flag, rsp_data} !== exp) begin n_err++; $display("FAIL wrap_flag got %b/%h want 0/%h", rsp_flag, rsp_data, exp[15:0]); end
    complete(g);
    exp_count = exp_count + 16'd1;
    #1;
    n_vec++; if (op_count !== exp_count || exp_count !== 16'h0000) begin n_err++; $display("FAIL wrap_count got %h want 0000", op_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_contention();
    test_basic_add();
    test_basic_mul();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the sequence ended");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_op_scheduler.md
Name: fpu_op_scheduler

Overview:
- Sequences and shares the 16-bit half-precision add and mul units between two requesters.
- Each requester submits one operation (op select plus two operands) through a valid/ready handshake.
- The scheduler arbitrates round-robin, holds the operands stable on the unit inputs, captures the selected unit's result and valid flag, and returns them through a per-requester response handshake.
- Sits between the pin-level nibble serializer/deserializer front end and the combinational add/mul instances.

Parameters:
- FP_W, 16, operand/result width.
- SETTLE_CYCLES, 1, cycles operands are held on the unit inputs before capture; legal range 1..15.
- N_REQ, 2, number of requesters; fixed at 2 for this revision.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  2  per-requester operation request.
- req_ready  out  2  one-hot accept; combinational in IDLE.
- req_op  in  2  per-requester op select: 1 = add, 0 = mul (same encoding as the chip select pin).
- req_a  in  2x16  per-requester operand A.
- req_b  in  2x16  per-requester operand B.
- rsp_valid  out  2  per-requester result available.
- rsp_ready  in  2  per-requester result consumed.
- rsp_data  out  16  result, shared by both requesters.
- rsp_flag  out  1  unit valid flag captured with the result.
- unit_a  out  16  registered operand A to add/mul.
- unit_b  out  16  registered operand B to add/mul.
- add_out  in  16  adder result.
- add_valid  in  1  adder valid.
- mul_out  in  16  multiplier result.
- mul_valid  in  1  multiplier valid.
- busy  out  1  high whenever state != IDLE.
- op_count  out  16  completed-operation counter.

Behaviour:
- Reset values (asynchronous): state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_flag=0, unit_a=0, unit_b=0, busy=0, op_count=0, last_grant=1 (so requester 0 wins the first contention).
- IDLE:
  - grant = round-robin over req_valid, preferring the requester that is not last_grant.
  - req_ready[grant]=1 only in IDLE with a valid request; req_ready=0 in all other states.
  - Transfer occurs when req_valid[g] && req_ready[g].
  - On transfer edge T: unit_a<=req_a[g], unit_b<=req_b[g], op_r<=req_op[g], owner<=g, last_grant<=g, settle_cnt<=SETTLE_CYCLES-1; state->ISSUE.
- ISSUE:
  - unit_a and unit_b are held constant.
  - When settle_cnt != 0: decrement settle_cnt.
  - When settle_cnt == 0: rsp_data<=op_r ? add_out : mul_out; rsp_flag<=op_r ? add_valid : mul_valid; state->RESP.
  - rsp_valid[owner] is high from edge T+SETTLE_CYCLES onward.
- RESP:
  - rsp_valid[owner]=1; rsp_data and rsp_flag are stable.
  - rsp_ready of the non-owner is ignored.
  - On rsp_ready[owner]: rsp_valid<=0, op_count<=op_count+1 (wraps 0xFFFF->0x0000), state->IDLE.
  - A new request can be accepted in the cycle after IDLE is re-entered, giving a minimum issue interval of SETTLE_CYCLES+2 cycles with rsp_ready held high.
- Simultaneous req_valid=2'b11: the grant alternates 0,1,0,1 under continuous contention.
- A single requester with continuous requests is granted every time; there is no starvation penalty.
- Requests may be withdrawn while req_ready=0; no state is affected.
- Operand/op changes on a requester after transfer do not affect the operation in flight.
- Reset mid-operation drops the in-flight op; no response is produced; op_count clears.
- Both units see the same operands; only the selected unit's output is captured.

Decomposition:
- Shared package fpu_pkg:
  - FP_W.
  - typedef enum op_t {OP_MUL=1'b0, OP_ADD=1'b1}.
  - typedef enum sched_state_t {IDLE, ISSUE, RESP}.
- Natural sub-module fpu_rr_arb2:
  - inputs: req[1:0], last_grant.
  - outputs: one-hot gnt[1:0], gnt_idx.
  - purely combinational and reusable by the nibble front end.

Test Plan:
- Basic add:
  - Stimulus: req0 op=1, a=0x3C00, b=0x4000, bench add model returns 0x4200 with valid=1, rsp_ready=1.
  - Response: rsp_valid[0] high at accept+SETTLE_CYCLES edges, rsp_data=0x4200, rsp_flag=1, op_count=1.
- Basic mul on requester 1:
  - Stimulus: req1 op=0, a=0x4000, b=0x4200, model returns 0x4600.
  - Response: rsp_valid[1]=1, rsp_valid[0]=0, rsp_data=0x4600.
- Contention:
  - Stimulus: req_valid=2'b11 held for four operations.
  - Response: grant order 0,1,0,1; each rsp_valid goes only to its owner; busy stays high throughout except one IDLE cycle between ops.
- Response backpressure:
  - Stimulus: rsp_ready[0]=0 for 5 cycles, rsp_ready[1]=1 throughout.
  - Response: rsp_valid[0] and rsp_data stable for the 5 cycles; no new req_ready; the op completes when rsp_ready[0] rises.
- Mid-op reset:
  - Stimulus: assert reset asynchronously during ISSUE with SETTLE_CYCLES=4.
  - Response: all outputs zero immediately; no rsp_valid after release; the next request is granted to requester 0.
- Counter wrap and flag pass-through:
  - Stimulus: preload op_count to 0xFFFF via 65535 ops (or force in sim), then one more op; model valid=0.
  - Response: op_count=0x0000 and rsp_flag=0.
